// File: rtl/ddr_cmn_zqcal_ctrl_if.sv
// Bundle between the CSR-side sequencer user and the ZQ calibration controller.
// Feature macro DDR_CMN_ZQCAL_MAJ_EN does not affect this interface.
interface ddr_cmn_zqcal_ctrl_if #(
    parameter int CODE_W   = 6,
    parameter int SETTLE_W = 8
);
    // Handshake: i_start is a single-cycle request, accepted only while o_busy is
    // low; o_busy then stays high until the cycle o_done (sticky) rises.
    logic                i_start;
    logic [SETTLE_W-1:0] i_settle_cycles;
    logic                i_comp;
    logic                o_cal_en;
    logic                o_pu_sel;
    logic [CODE_W-1:0]   o_code;
    logic [CODE_W-1:0]   o_pd_code;
    logic [CODE_W-1:0]   o_pu_code;
    logic                o_busy;
    logic                o_done;
    logic                o_error;

    modport master (
        output i_start, i_settle_cycles, i_comp,
        input  o_cal_en, o_pu_sel, o_code, o_pd_code, o_pu_code, o_busy, o_done, o_error
    );

    modport slave (
        input  i_start, i_settle_cycles, i_comp,
        output o_cal_en, o_pu_sel, o_code, o_pd_code, o_pu_code, o_busy, o_done, o_error
    );
endinterface

// File: rtl/ddr_cmn_zqcal_ctrl.sv
// ZQ calibration sequencer: SAR search of pull-down then pull-up driver code.
// Define DDR_CMN_ZQCAL_MAJ_EN for 3-sample 2-of-3 majority comparator decisions.
module ddr_cmn_zqcal_ctrl #(
    parameter int CODE_W   = 6,
    parameter int SETTLE_W = 8
) (
    input  logic                  i_hclk,
    input  logic                  i_hreset,
    ddr_cmn_zqcal_ctrl_if.slave   bus,
    output logic [2:0]            dbg_state
);
    localparam int IDX_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;
    localparam logic [IDX_W-1:0]  IDX_TOP = IDX_W'(CODE_W - 1);
    localparam logic [CODE_W-1:0] MID     = {1'b1, {(CODE_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_TRIAL  = 3'd1,
        S_WAIT   = 3'd2,
        S_SAMPLE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t              state, state_nxt;
    logic                phase;
    logic [IDX_W-1:0]    idx;
    logic [SETTLE_W-1:0] cnt;
    logic [CODE_W-1:0]   code;
    logic [CODE_W-1:0]   pd_code, pu_code;
    logic                done, error;
    logic                comp_s1, comp_s2;
    logic                decision, sample_last;
    logic [SETTLE_W-1:0] settle_eff;
    logic [CODE_W-1:0]   bit_mask, decided;

`ifdef DDR_CMN_ZQCAL_MAJ_EN
    logic [1:0] samp_cnt;
    logic [1:0] samp_hist;
    assign sample_last = (samp_cnt == 2'd2);
    assign decision    = (samp_hist[1] & samp_hist[0]) | (samp_hist[1] & comp_s2) |
                         (samp_hist[0] & comp_s2);
`else
    assign sample_last = 1'b1;
    assign decision    = comp_s2;
`endif

    // The 2-flop synchroniser delay is covered by the minimum settle of 2.
    assign settle_eff = (bus.i_settle_cycles < SETTLE_W'(2)) ? SETTLE_W'(2) : bus.i_settle_cycles;
    assign bit_mask   = CODE_W'(1) << idx;
    assign decided    = decision ? code : (code & ~bit_mask);

    always_ff @(posedge i_hclk or posedge i_hreset) begin
        if (i_hreset) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (bus.i_start) state_nxt = S_TRIAL;
            S_TRIAL:  state_nxt = S_WAIT;
            S_WAIT:   if (cnt == '0) state_nxt = S_SAMPLE;
            S_SAMPLE: if (sample_last) state_nxt = (idx != '0 || !phase) ? S_TRIAL : S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.o_cal_en  = (state != S_IDLE);
        bus.o_busy    = (state != S_IDLE);
        bus.o_pu_sel  = phase;
        bus.o_code    = code;
        bus.o_pd_code = pd_code;
        bus.o_pu_code = pu_code;
        bus.o_done    = done;
        bus.o_error   = error;
        dbg_state     = state;
    end

    // code holds the current trial value; it is only rewritten when entering TRIAL.
    always_ff @(posedge i_hclk or posedge i_hreset) begin
        if (i_hreset) begin
            phase     <= 1'b0;
            idx       <= IDX_TOP;
            cnt       <= '0;
            code      <= '0;
            pd_code   <= MID;
            pu_code   <= MID;
            done      <= 1'b0;
            error     <= 1'b0;
            comp_s1   <= 1'b0;
            comp_s2   <= 1'b0;
`ifdef DDR_CMN_ZQCAL_MAJ_EN
            samp_cnt  <= 2'd0;
            samp_hist <= 2'b00;
`endif
        end else begin
            comp_s1 <= bus.i_comp;
            comp_s2 <= comp_s1;
            case (state)
                S_IDLE: begin
                    if (bus.i_start) begin
                        done  <= 1'b0;
                        error <= 1'b0;
                        phase <= 1'b0;
                        idx   <= IDX_TOP;
                        code  <= MID;
                    end
                end
                S_TRIAL: cnt <= settle_eff;
                S_WAIT: begin
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                S_SAMPLE: begin
                    if (sample_last) begin
`ifdef DDR_CMN_ZQCAL_MAJ_EN
                        samp_cnt <= 2'd0;
`endif
                        if (idx != '0) begin
                            code <= decided | (bit_mask >> 1);
                            idx  <= idx - 1'b1;
                        end else if (!phase) begin
                            pd_code <= decided;
                            phase   <= 1'b1;
                            idx     <= IDX_TOP;
                            code    <= MID;
                        end else begin
                            pu_code <= decided;
                        end
                    end
`ifdef DDR_CMN_ZQCAL_MAJ_EN
                    else begin
                        samp_hist <= {samp_hist[0], comp_s2};
                        samp_cnt  <= samp_cnt + 2'd1;
                    end
`endif
                end
                S_DONE: begin
                    done  <= 1'b1;
                    error <= (pd_code == '0) || (pd_code == '1) ||
                             (pu_code == '0) || (pu_code == '1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ddr_cmn_zqcal_ctrl.sv
// Directed bench for ddr_cmn_zqcal_ctrl; expected codes and latencies are hand-computed.
// With DDR_CMN_ZQCAL_MAJ_EN defined, each bit costs two extra clocks and the glitch test runs.
module tb_ddr_cmn_zqcal_ctrl;
`ifdef DDR_CMN_ZQCAL_MAJ_EN
    localparam int EXTRA = 2;
`else
    localparam int EXTRA = 0;
`endif

    logic       clk;
    logic       rst;
    logic [2:0] dbg_state;
    logic [5:0] pd_t, pu_t;
    int         comp_mode;
    logic       glitch;
    int         checks;
    int         errors;

    ddr_cmn_zqcal_ctrl_if #(.CODE_W(6), .SETTLE_W(8)) bus ();

    ddr_cmn_zqcal_ctrl #(.CODE_W(6), .SETTLE_W(8)) dut (
        .i_hclk    (clk),
        .i_hreset  (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Analog cell model: comparator high while trial code is at or below the target.
    assign bus.i_comp = (comp_mode == 1) ? 1'b1 :
                        (comp_mode == 2) ? 1'b0 :
                        ((bus.o_code <= (bus.o_pu_sel ? pu_t : pd_t)) ^ glitch);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.i_start = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic start_cal();
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!bus.o_done && n < 1000) begin
            tick();
            n++;
        end
        if (!bus.o_done) n = -1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.o_cal_en !== 1'b0) begin errors++; $display("FAIL rst_cal_en: got %b expected 0", bus.o_cal_en); end
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", bus.o_busy); end
        checks++; if (bus.o_code !== 6'd0) begin errors++; $display("FAIL rst_code: got %0d expected 0", bus.o_code); end
        checks++; if ({bus.o_pu_sel, bus.o_done, bus.o_error} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b expected 000", {bus.o_pu_sel, bus.o_done, bus.o_error}); end
        checks++; if (bus.o_pd_code !== 6'h20 || bus.o_pu_code !== 6'h20) begin errors++; $display("FAIL rst_codes: got %h/%h expected 20/20", bus.o_pd_code, bus.o_pu_code); end
        checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL rst_state: got %0d expected 0", dbg_state); end
    endtask

    task automatic test_nominal();
        int n;
        int pb;
        pb = 4 + 3 + EXTRA;
        bus.i_settle_cycles = 8'd4; pd_t = 6'd37; pu_t = 6'd22; comp_mode = 0;
        start_cal();
        checks++; if (bus.o_busy !== 1'b1 || bus.o_cal_en !== 1'b1) begin errors++; $display("FAIL nom_busy_n1: got %b%b expected 11", bus.o_busy, bus.o_cal_en); end
        checks++; if (bus.o_code !== 6'd32) begin errors++; $display("FAIL nom_code_n1: got %0d expected 32", bus.o_code); end
        n = 0;
        while (!bus.o_done && n < 1000) begin
            tick();
            n++;
            if (n == 6 * pb - 1) begin
                checks++; if (bus.o_pd_code !== 6'd32) begin errors++; $display("FAIL nom_pd_early: got %0d expected 32", bus.o_pd_code); end
            end
            if (n == 6 * pb) begin
                checks++; if (bus.o_pd_code !== 6'd37 || bus.o_pu_sel !== 1'b1) begin errors++; $display("FAIL nom_pd_latch: got %0d sel %b expected 37 sel 1", bus.o_pd_code, bus.o_pu_sel); end
            end
            if (n == 12 * pb) begin
                checks++; if (bus.o_pu_code !== 6'd22 || bus.o_busy !== 1'b1) begin errors++; $display("FAIL nom_pu_latch: got %0d busy %b expected 22 busy 1", bus.o_pu_code, bus.o_busy); end
            end
        end
        checks++; if (n != 12 * pb + 1) begin errors++; $display("FAIL nom_latency: got %0d expected %0d", n, 12 * pb + 1); end
        checks++; if (bus.o_pd_code !== 6'd37 || bus.o_pu_code !== 6'd22) begin errors++; $display("FAIL nom_codes: got %0d/%0d expected 37/22", bus.o_pd_code, bus.o_pu_code); end
        checks++; if (bus.o_error !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_cal_en !== 1'b0) begin errors++; $display("FAIL nom_flags: got err %b busy %b en %b expected 0 0 0", bus.o_error, bus.o_busy, bus.o_cal_en); end
        checks++; if (bus.o_code !== 6'd23) begin errors++; $display("FAIL nom_code_hold: got %0d expected 23", bus.o_code); end
    endtask

    task automatic test_settle_clamp();
        int n;
        bus.i_settle_cycles = 8'd0; pd_t = 6'd10; pu_t = 6'd53; comp_mode = 0;
        start_cal();
        wait_done(n);
        checks++; if (n != 12 * (5 + EXTRA) + 1) begin errors++; $display("FAIL clamp0_latency: got %0d expected %0d", n, 12 * (5 + EXTRA) + 1); end
        checks++; if (bus.o_pd_code !== 6'd10 || bus.o_pu_code !== 6'd53) begin errors++; $display("FAIL clamp0_codes: got %0d/%0d expected 10/53", bus.o_pd_code, bus.o_pu_code); end
        checks++; if (bus.o_code !== 6'd53) begin errors++; $display("FAIL clamp0_code_hold: got %0d expected 53", bus.o_code); end
        bus.i_settle_cycles = 8'd2;
        start_cal();
        wait_done(n);
        checks++; if (n != 12 * (5 + EXTRA) + 1) begin errors++; $display("FAIL settle2_latency: got %0d expected %0d", n, 12 * (5 + EXTRA) + 1); end
        checks++; if (bus.o_pd_code !== 6'd10 || bus.o_pu_code !== 6'd53) begin errors++; $display("FAIL settle2_codes: got %0d/%0d expected 10/53", bus.o_pd_code, bus.o_pu_code); end
    endtask

    task automatic test_saturation();
        int n;
        bus.i_settle_cycles = 8'd3; comp_mode = 1;
        start_cal();
        wait_done(n);
        checks++; if (n != 12 * (6 + EXTRA) + 1) begin errors++; $display("FAIL sat1_latency: got %0d expected %0d", n, 12 * (6 + EXTRA) + 1); end
        checks++; if (bus.o_pd_code !== 6'd63 || bus.o_pu_code !== 6'd63) begin errors++; $display("FAIL sat1_codes: got %0d/%0d expected 63/63", bus.o_pd_code, bus.o_pu_code); end
        checks++; if (bus.o_error !== 1'b1) begin errors++; $display("FAIL sat1_error: got %b expected 1", bus.o_error); end
        comp_mode = 2;
        start_cal();
        checks++; if (bus.o_error !== 1'b0 || bus.o_done !== 1'b0) begin errors++; $display("FAIL sat0_clear: got err %b done %b expected 0 0", bus.o_error, bus.o_done); end
        wait_done(n);
        checks++; if (bus.o_pd_code !== 6'd0 || bus.o_pu_code !== 6'd0) begin errors++; $display("FAIL sat0_codes: got %0d/%0d expected 0/0", bus.o_pd_code, bus.o_pu_code); end
        checks++; if (bus.o_error !== 1'b1 || n < 0) begin errors++; $display("FAIL sat0_error: got err %b cycles %0d expected err 1", bus.o_error, n); end
        checks++; if (bus.o_code !== 6'd1) begin errors++; $display("FAIL sat0_code_hold: got %0d expected 1", bus.o_code); end
    endtask

    task automatic test_start_while_busy();
        int first_done;
        int rises;
        logic prev_done;
        bus.i_settle_cycles = 8'd4; pd_t = 6'd37; pu_t = 6'd22; comp_mode = 0;
        start_cal();
        first_done = -1; rises = 0; prev_done = bus.o_done;
        for (int n = 1; n <= 12 * (7 + EXTRA) + 20; n++) begin
            bus.i_start = (n == 10 || n == 40);
            tick();
            if (bus.o_done && !prev_done) begin
                rises++;
                if (first_done < 0) first_done = n;
            end
            prev_done = bus.o_done;
        end
        bus.i_start = 1'b0;
        checks++; if (first_done != 12 * (7 + EXTRA) + 1) begin errors++; $display("FAIL busy_latency: got %0d expected %0d", first_done, 12 * (7 + EXTRA) + 1); end
        checks++; if (rises != 1) begin errors++; $display("FAIL busy_done_count: got %0d expected 1", rises); end
        checks++; if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b1) begin errors++; $display("FAIL busy_idle_after: got busy %b done %b expected 0 1", bus.o_busy, bus.o_done); end
        checks++; if (bus.o_pd_code !== 6'd37 || bus.o_pu_code !== 6'd22) begin errors++; $display("FAIL busy_codes: got %0d/%0d expected 37/22", bus.o_pd_code, bus.o_pu_code); end
    endtask

`ifdef DDR_CMN_ZQCAL_MAJ_EN
    task automatic test_majority();
        int n;
        bus.i_settle_cycles = 8'd4; pd_t = 6'd37; pu_t = 6'd22; comp_mode = 0;
        start_cal();
        n = 0;
        while (!bus.o_done && n < 1000) begin
            glitch = (n + 1 == 6);
            tick();
            n++;
        end
        glitch = 1'b0;
        checks++; if (n != 109) begin errors++; $display("FAIL maj_latency: got %0d expected 109", n); end
        checks++; if (bus.o_pd_code !== 6'd37 || bus.o_pu_code !== 6'd22) begin errors++; $display("FAIL maj_codes: got %0d/%0d expected 37/22", bus.o_pd_code, bus.o_pu_code); end
    endtask
`endif

    task automatic test_reset_mid_cal();
        bus.i_settle_cycles = 8'd4; pd_t = 6'd11; pu_t = 6'd44; comp_mode = 0;
        start_cal();
        repeat (6 * (7 + EXTRA) + 8) tick();
        checks++; if (bus.o_pu_sel !== 1'b1 || bus.o_busy !== 1'b1) begin errors++; $display("FAIL midrst_in_pu: got sel %b busy %b expected 1 1", bus.o_pu_sel, bus.o_busy); end
        rst = 1'b1;
        #1;
        checks++; if ({bus.o_cal_en, bus.o_pu_sel, bus.o_busy, bus.o_done, bus.o_error} !== 5'b00000) begin errors++; $display("FAIL midrst_flags: got %b expected 00000", {bus.o_cal_en, bus.o_pu_sel, bus.o_busy, bus.o_done, bus.o_error}); end
        checks++; if (bus.o_code !== 6'd0 || bus.o_pd_code !== 6'h20 || bus.o_pu_code !== 6'h20) begin errors++; $display("FAIL midrst_codes: got %h/%h/%h expected 00/20/20", bus.o_code, bus.o_pd_code, bus.o_pu_code); end
        checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL midrst_state: got %0d expected 0", dbg_state); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; bus.i_start = 1'b0; bus.i_settle_cycles = 8'd4;
        pd_t = 6'd0; pu_t = 6'd0; comp_mode = 0; glitch = 1'b0;
        test_reset();
        test_nominal();
        test_settle_clamp();
        test_saturation();
        test_start_while_busy();
`ifdef DDR_CMN_ZQCAL_MAJ_EN
        test_majority();
`endif
        test_reset_mid_cal();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ddr_cmn_zqcal_ctrl.md
# ddr_cmn_zqcal_ctrl

Sequencer for ZQ impedance calibration in the DDR common block. On a start request it runs a successive-approximation (SAR) search over the pull-down driver code, then over the pull-up driver code. It sources the calibration enable and trial code for the analog ZQ macro and samples the macro's comparator output. It sits between the common CSR block (start, settle time, result/status readback) and the analog ZQ calibration cell, replacing manual software stepping of the ZQ code field.

## Interface
Parameters:
- CODE_W, 6, width of the pull-up/pull-down driver code.
- SETTLE_W, 8, width of the settle-time configuration.

Ports (reset i_hreset, asynchronous, active-high; clock i_hclk):
- i_hclk  input  1  CSR/AHB clock; all logic is on this clock.
- i_hreset  input  1  asynchronous active-high reset.
- i_start  input  1  single-cycle calibration request; honoured only in IDLE.
- i_settle_cycles  input  SETTLE_W  analog settle wait per trial, in clocks; values below 2 are treated as 2.
- i_comp  input  1  comparator output from the analog cell; asynchronous, synchronised internally with 2 flops.
- o_cal_en  output  1  enables the ZQ comparator/driver in the analog cell.
- o_pu_sel  output  1  0 = pull-down phase, 1 = pull-up phase.
- o_code  output  CODE_W  trial code driven to the analog cell.
- o_pd_code  output  CODE_W  final pull-down result.
- o_pu_code  output  CODE_W  final pull-up result.
- o_busy  output  1  calibration in progress.
- o_done  output  1  sticky completion flag; cleared by the next accepted start.
- o_error  output  1  sticky saturation flag; cleared by the next accepted start.

## Operation
- States: IDLE, TRIAL, WAIT, SAMPLE, DONE. Internal regs: phase (PD/PU), bit index, settle counter, working code.
- IDLE:
  - On i_start: clear o_done and o_error, set phase=PD, bit index=CODE_W-1, working code=0, then go to TRIAL.
  - Holding i_start high repeatedly retriggers only after the FSM returns to IDLE.
- TRIAL (1 cycle):
  - o_code = working code with the current bit set.
  - Load the settle counter with max(i_settle_cycles,2), then go to WAIT.
- WAIT: decrement the counter each cycle. At 0, go to SAMPLE.
- SAMPLE (1 cycle):
  - Synchronised comp=1 keeps the bit; comp=0 clears it.
  - If bit index > 0: decrement the index and go to TRIAL.
  - Else, in PD phase: latch o_pd_code, set phase=PU, reset the index and working code, then go to TRIAL.
  - Else, in PU phase: latch o_pu_code and go to DONE.
- DONE (1 cycle): set o_done, go to IDLE.
- o_error is set in DONE if either final code is all-zeros or all-ones.
- o_cal_en=1 and o_busy=1 in every state except IDLE. o_pu_sel follows phase.
- o_code holds its last trial value while IDLE.
- i_settle_cycles and i_comp are sampled live. Software must not change i_settle_cycles while o_busy is set.
- Reset mid-operation: all state clears asynchronously, and results return to their reset values.

## Timing
- Reset values:
  - o_cal_en=0, o_pu_sel=0, o_code=0, o_busy=0, o_done=0, o_error=0.
  - o_pd_code = o_pu_code = mid-scale (MSB set, others 0).
  - FSM in IDLE.
- i_start registered in cycle N: o_busy=1 and o_code=MSB at N+1.
- Per-bit cost with S = max(i_settle_cycles,2): 1 TRIAL + (S+1) WAIT + 1 SAMPLE = S+3 clocks.
- Total from accepted start to o_done=1: 2·CODE_W·(S+3)+1 clocks. o_busy drops in the same cycle o_done rises.
- The 2-flop synchroniser latency (2 clocks) is absorbed by the minimum settle of 2.
- o_pd_code updates on the clock after the PD-phase final SAMPLE. o_pu_code updates on the clock entering DONE.

## Configuration
- DDR_CMN_ZQCAL_MAJ_EN defined:
  - SAMPLE lasts 3 cycles and takes 3 consecutive synchronised comparator samples.
  - The bit decision is the 2-of-3 majority.
  - Per-bit cost becomes S+5; total becomes 2·CODE_W·(S+5)+1.
- Undefined: single-sample decision exactly as in Operation. The majority logic and its sample counter are not present.

## Test plan
- Reset: assert i_hreset mid-calibration (during PU phase) → all outputs return to reset values immediately. FSM IDLE; o_pd_code=o_pu_code=6'h20.
- Nominal (CODE_W=6, settle=4): comparator model comp=(o_code<=target), PD target 37, PU target 22 → o_pd_code=37, o_pu_code=22, o_error=0, o_done 85 clocks after accepted start.
- Settle clamp: i_settle_cycles=0 → same results as settle=2. Start-to-done = 61 clocks.
- Saturation: comp tied 1 → both codes 63, o_error=1. Then comp tied 0 and restart → o_error, o_done cleared at start, codes 0, o_error=1 at end.
- Start while busy: pulse i_start at cycles 10 and 40 after the first start → ignored; single o_done at 85; results unchanged.
- Majority (DDR_CMN_ZQCAL_MAJ_EN, settle=4): a single-cycle glitch on i_comp during SAMPLE of the MSB trial → decision unaffected, o_pd_code=37. Done at 2·6·9+1 = 109 clocks.
